// File: rtl/move_sequencer.sv
// move_sequencer: walks a byte-wide descriptor table and issues each 6-byte move
// descriptor to the data-move engine. It waits for move_done after each descriptor
// and aborts the sequence if the engine stalls for longer than TIMEOUT cycles.
module move_sequencer #(
  parameter int MAX_CMDS = 64,
  parameter int TIMEOUT  = 1000
) (
  input  logic        sys_clk_50m,
  input  logic        sys_rst,
  input  logic        seq_start,
  output logic        seq_busy,
  output logic        seq_done,
  output logic        seq_err,
  output logic [7:0]  err_cnt,
  output logic [5:0]  cmd_idx,
  output logic [8:0]  tbl_raddr,
  input  logic [7:0]  tbl_rdata,
  output logic        byte6_valid,
  output logic [47:0] byte6_data,
  input  logic        move_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_CNT    = 3'd1,
    RD_DESC   = 3'd2,
    ISSUE     = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  // Largest usable count, and the last timeout count value that still allows a move_done.
  localparam logic [7:0]  MAX_N    = 8'(MAX_CMDS);
  localparam logic [6:0]  MAX_N7   = 7'(MAX_CMDS);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [1:0]   phase_q, phase_d;        // 0: address out, 2: data valid and captured
  logic [2:0]   byte_idx_q, byte_idx_d;  // descriptor byte being fetched
  logic [5:0]   cmd_idx_q, cmd_idx_d;
  logic [6:0]   n_cmds_q, n_cmds_d;      // effective (clamped) descriptor count
  logic [15:0]  tmo_cnt_q, tmo_cnt_d;
  logic [39:0]  acc_q, acc_d;            // first five descriptor bytes, oldest in the MSBs
  logic [47:0]  byte6_data_q, byte6_data_d;
  logic         byte6_valid_q, byte6_valid_d;
  logic         seq_busy_q, seq_busy_d;
  logic         seq_done_q, seq_done_d;
  logic         seq_err_q, seq_err_d;
  logic [7:0]   err_cnt_q, err_cnt_d;
  logic [8:0]   tbl_raddr_q, tbl_raddr_d;
  logic         last_cmd;
  logic [7:0]   err_cnt_inc;

  // Byte address of a descriptor byte: 1 + 6*idx + byte index (max 384, fits 9 bits).
  function automatic logic [8:0] desc_addr(input logic [5:0] idx, input logic [2:0] bidx);
    return 9'd1 + ({3'b000, idx} * 9'd6) + {6'b000000, bidx};
  endfunction

  assign last_cmd    = ({1'b0, cmd_idx_q} == (n_cmds_q - 7'd1));
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : (err_cnt_q + 8'd1);

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    byte_idx_d    = byte_idx_q;
    cmd_idx_d     = cmd_idx_q;
    n_cmds_d      = n_cmds_q;
    tmo_cnt_d     = tmo_cnt_q;
    acc_d         = acc_q;
    byte6_data_d  = byte6_data_q;
    byte6_valid_d = 1'b0;
    seq_busy_d    = seq_busy_q;
    seq_done_d    = 1'b0;
    seq_err_d     = seq_err_q;
    err_cnt_d     = err_cnt_q;
    tbl_raddr_d   = tbl_raddr_q;

    case (state_q)
      IDLE: begin
        if (seq_start) begin
          state_d     = RD_CNT;
          seq_busy_d  = 1'b1;
          seq_err_d   = 1'b0;
          tbl_raddr_d = 9'd0;
          phase_d     = 2'd0;
          cmd_idx_d   = 6'd0;
        end
      end

      RD_CNT: begin
        if (phase_q == 2'd2) begin
          phase_d = 2'd0;
          if (tbl_rdata == 8'd0) begin
            state_d    = IDLE;
            seq_busy_d = 1'b0;
            seq_done_d = 1'b1;
          end else begin
            if (tbl_rdata > MAX_N) begin
              n_cmds_d  = MAX_N7;
              seq_err_d = 1'b1;
              err_cnt_d = err_cnt_inc;
            end else begin
              n_cmds_d = tbl_rdata[6:0];
            end
            state_d     = RD_DESC;
            byte_idx_d  = 3'd0;
            tbl_raddr_d = desc_addr(cmd_idx_q, 3'd0);
          end
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end

      RD_DESC: begin
        if (phase_q == 2'd2) begin
          phase_d = 2'd0;
          acc_d   = {acc_q[31:0], tbl_rdata};
          if (byte_idx_q == 3'd5) begin
            byte6_data_d  = {acc_q, tbl_rdata};
            byte6_valid_d = 1'b1;
            state_d       = ISSUE;
          end else begin
            byte_idx_d  = byte_idx_q + 3'd1;
            tbl_raddr_d = desc_addr(cmd_idx_q, byte_idx_q + 3'd1);
          end
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end

      ISSUE: begin
        // move_done is deliberately not looked at in the strobe cycle.
        state_d   = WAIT_DONE;
        tmo_cnt_d = 16'd0;
      end

      WAIT_DONE: begin
        // move_done wins over a timeout landing in the same cycle.
        if (move_done) begin
          if (last_cmd) begin
            state_d    = IDLE;
            seq_busy_d = 1'b0;
            seq_done_d = 1'b1;
          end else begin
            cmd_idx_d   = cmd_idx_q + 6'd1;
            byte_idx_d  = 3'd0;
            phase_d     = 2'd0;
            tbl_raddr_d = desc_addr(cmd_idx_q + 6'd1, 3'd0);
            state_d     = RD_DESC;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d    = IDLE;
          seq_busy_d = 1'b0;
          seq_done_d = 1'b1;
          seq_err_d  = 1'b1;
          err_cnt_d  = err_cnt_inc;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d    = IDLE;
        seq_busy_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops everything at once, with no seq_done.
  always_ff @(posedge sys_clk_50m or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      phase_q       <= 2'd0;
      byte_idx_q    <= 3'd0;
      cmd_idx_q     <= 6'd0;
      n_cmds_q      <= 7'd0;
      tmo_cnt_q     <= 16'd0;
      acc_q         <= 40'd0;
      byte6_data_q  <= 48'd0;
      byte6_valid_q <= 1'b0;
      seq_busy_q    <= 1'b0;
      seq_done_q    <= 1'b0;
      seq_err_q     <= 1'b0;
      err_cnt_q     <= 8'd0;
      tbl_raddr_q   <= 9'd0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      byte_idx_q    <= byte_idx_d;
      cmd_idx_q     <= cmd_idx_d;
      n_cmds_q      <= n_cmds_d;
      tmo_cnt_q     <= tmo_cnt_d;
      acc_q         <= acc_d;
      byte6_data_q  <= byte6_data_d;
      byte6_valid_q <= byte6_valid_d;
      seq_busy_q    <= seq_busy_d;
      seq_done_q    <= seq_done_d;
      seq_err_q     <= seq_err_d;
      err_cnt_q     <= err_cnt_d;
      tbl_raddr_q   <= tbl_raddr_d;
    end
  end

  assign seq_busy    = seq_busy_q;
  assign seq_done    = seq_done_q;
  assign seq_err     = seq_err_q;
  assign err_cnt     = err_cnt_q;
  assign cmd_idx     = cmd_idx_q;
  assign tbl_raddr   = tbl_raddr_q;
  assign byte6_valid = byte6_valid_q;
  assign byte6_data  = byte6_data_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: table RAM model with 2-cycle read latency,
// move_done responder, and cycle-accurate checks relative to the seq_start cycle.
module tb_move_sequencer;

  localparam int MAXC = 4;
  localparam int TMO  = 20;

  logic        sys_clk_50m = 1'b0;
  logic        sys_rst     = 1'b1;
  logic        seq_start   = 1'b0;
  logic        move_done   = 1'b0;
  logic        seq_busy;
  logic        seq_done;
  logic        seq_err;
  logic [7:0]  err_cnt;
  logic [5:0]  cmd_idx;
  logic [8:0]  tbl_raddr;
  logic [7:0]  tbl_rdata;
  logic        byte6_valid;
  logic [47:0] byte6_data;

  move_sequencer #(.MAX_CMDS(MAXC), .TIMEOUT(TMO)) dut (
    .sys_clk_50m (sys_clk_50m),
    .sys_rst     (sys_rst),
    .seq_start   (seq_start),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done),
    .seq_err     (seq_err),
    .err_cnt     (err_cnt),
    .cmd_idx     (cmd_idx),
    .tbl_raddr   (tbl_raddr),
    .tbl_rdata   (tbl_rdata),
    .byte6_valid (byte6_valid),
    .byte6_data  (byte6_data),
    .move_done   (move_done)
  );

  always #10 sys_clk_50m = ~sys_clk_50m;

  // Table RAM: data appears two cycles after the address.
  logic [7:0] mem [0:511];
  logic [7:0] pipe1;
  always @(posedge sys_clk_50m) begin
    pipe1     <= mem[tbl_raddr];
    tbl_rdata <= pipe1;
  end

  int checks   = 0;
  int failures = 0;

  // Results of the last run_seq, cycles counted from the start-sampling edge.
  int          n_valid;
  int          valid_cyc [16];
  logic [47:0] valid_data [16];
  int          done_cyc;

  task automatic do_reset();
    sys_rst = 1'b1;
    seq_start = 1'b0;
    move_done = 1'b0;
    @(negedge sys_clk_50m);
    @(negedge sys_clk_50m);
    sys_rst = 1'b0;
  endtask

  task automatic load_normal(input logic [7:0] n);
    logic [47:0] d0;
    logic [47:0] d1;
    d0 = 48'h5A1234091000;
    d1 = 48'h830020000040;
    mem[0] = n;
    for (int i = 0; i < 6; i++) begin
      mem[1 + i] = d0[47 - 8*i -: 8];
      mem[7 + i] = d1[47 - 8*i -: 8];
    end
    for (int i = 13; i < 19; i++) mem[i] = 8'(i);
  endtask

  // Pulses seq_start and follows one sequence until seq_done (bounded by budget).
  // md_delay<0: never answer; extra_start_at: cycle of a stray start; md_in_issue: pulse move_done on the strobe.
  task automatic run_seq(input int md_delay, input int extra_start_at, input bit md_in_issue, input int budget);
    int c;
    int last_v;
    n_valid  = 0;
    done_cyc = -1;
    last_v   = -1000;
    @(negedge sys_clk_50m);
    seq_start = 1'b1;
    c = 0;
    while (done_cyc < 0 && c < budget) begin
      @(negedge sys_clk_50m);
      c++;
      seq_start = (c == extra_start_at);
      move_done = 1'b0;
      if (c == 1) begin
        checks++;
        if (seq_busy !== 1'b1 || tbl_raddr !== 9'd0) begin
          failures++;
          $display("FAIL start_busy_addr got busy=%b raddr=%0d exp busy=1 raddr=0", seq_busy, tbl_raddr);
        end
      end
      if (byte6_valid === 1'b1) begin
        if (n_valid < 16) begin
          valid_cyc[n_valid]  = c;
          valid_data[n_valid] = byte6_data;
        end
        n_valid++;
        last_v = c;
        if (md_in_issue) move_done = 1'b1;
      end
      if (md_delay >= 0 && c == last_v + md_delay) move_done = 1'b1;
      if (seq_done === 1'b1) begin
        done_cyc = c;
        checks++;
        if (seq_busy !== 1'b0) begin
          failures++;
          $display("FAIL busy_at_done got=%b exp=0", seq_busy);
        end
      end
    end
    seq_start = 1'b0;
    move_done = 1'b0;
    if (done_cyc < 0) begin
      checks++;
      failures++;
      $display("FAIL seq_done_wait got=none exp=seq_done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk_50m);
    checks++;
    if ({seq_busy, seq_done, seq_err, byte6_valid, err_cnt, cmd_idx, tbl_raddr, byte6_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b done=%b err=%b valid=%b cnt=%0d idx=%0d addr=%0d data=%h exp all zero",
               seq_busy, seq_done, seq_err, byte6_valid, err_cnt, cmd_idx, tbl_raddr, byte6_data);
    end
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk_50m);
    checks++;
    if (seq_busy !== 1'b0 || seq_done !== 1'b0 || byte6_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b done=%b valid=%b exp 0 0 0", seq_busy, seq_done, byte6_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_normal();
    do_reset();
    load_normal(8'd2);
    run_seq(5, -1, 1'b0, 200);
    checks++;
    if (n_valid !== 2) begin failures++; $display("FAIL normal_nvalid got=%0d exp=2", n_valid); end
    checks++;
    if (valid_cyc[0] !== 22 || valid_data[0] !== 48'h5A1234091000) begin
      failures++;
      $display("FAIL normal_desc0 got cyc=%0d data=%h exp cyc=22 data=5a1234091000", valid_cyc[0], valid_data[0]);
    end
    checks++;
    if (valid_cyc[1] !== 46 || valid_data[1] !== 48'h830020000040) begin
      failures++;
      $display("FAIL normal_desc1 got cyc=%0d data=%h exp cyc=46 data=830020000040", valid_cyc[1], valid_data[1]);
    end
    checks++;
    if (done_cyc !== 52) begin failures++; $display("FAIL normal_done_cyc got=%0d exp=52", done_cyc); end
    checks++;
    if (seq_err !== 1'b0 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL normal_err got err=%b cnt=%0d exp err=0 cnt=0", seq_err, err_cnt);
    end
    checks++;
    if (byte6_data !== 48'h830020000040) begin
      failures++;
      $display("FAIL normal_data_hold got=%h exp=830020000040", byte6_data);
    end
    $display("test_normal done: strobes=%0d done_cyc=%0d", n_valid, done_cyc);
  endtask

  task automatic test_empty();
    mem[0] = 8'd0;
    run_seq(5, -1, 1'b0, 50);
    checks++;
    if (done_cyc !== 4) begin failures++; $display("FAIL empty_done_cyc got=%0d exp=4", done_cyc); end
    checks++;
    if (n_valid !== 0) begin failures++; $display("FAIL empty_nvalid got=%0d exp=0", n_valid); end
    checks++;
    if (seq_err !== 1'b0) begin failures++; $display("FAIL empty_err got=%b exp=0", seq_err); end
    $display("test_empty done: done_cyc=%0d", done_cyc);
  endtask

  task automatic test_timeout();
    do_reset();
    load_normal(8'd3);
    run_seq(-1, -1, 1'b0, 200);
    checks++;
    if (n_valid !== 1) begin failures++; $display("FAIL tmo_nvalid got=%0d exp=1", n_valid); end
    checks++;
    if (done_cyc !== 43) begin failures++; $display("FAIL tmo_done_cyc got=%0d exp=43", done_cyc); end
    checks++;
    if (seq_err !== 1'b1 || err_cnt !== 8'd1 || cmd_idx !== 6'd0) begin
      failures++;
      $display("FAIL tmo_status got err=%b cnt=%0d idx=%0d exp err=1 cnt=1 idx=0", seq_err, err_cnt, cmd_idx);
    end
    $display("test_timeout done: done_cyc=%0d", done_cyc);
    // move_done on the very cycle the timeout would fire is a success.
    load_normal(8'd2);
    run_seq(20, -1, 1'b0, 200);
    checks++;
    if (n_valid !== 2 || valid_cyc[1] !== 61) begin
      failures++;
      $display("FAIL tmo_edge_next got n=%0d cyc=%0d exp n=2 cyc=61", n_valid, valid_cyc[1]);
    end
    checks++;
    if (done_cyc !== 82 || seq_err !== 1'b0 || err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL tmo_edge_end got done=%0d err=%b cnt=%0d exp done=82 err=0 cnt=1", done_cyc, seq_err, err_cnt);
    end
    $display("test_timeout edge done: done_cyc=%0d", done_cyc);
  endtask

  task automatic test_clamp();
    do_reset();
    mem[0] = 8'd100;
    for (int i = 1; i < 40; i++) mem[i] = 8'(i);
    run_seq(3, -1, 1'b0, 300);
    checks++;
    if (n_valid !== 4) begin failures++; $display("FAIL clamp_nvalid got=%0d exp=4", n_valid); end
    checks++;
    if (valid_cyc[3] !== 88 || valid_data[3] !== 48'h131415161718) begin
      failures++;
      $display("FAIL clamp_last_desc got cyc=%0d data=%h exp cyc=88 data=131415161718", valid_cyc[3], valid_data[3]);
    end
    checks++;
    if (done_cyc !== 92) begin failures++; $display("FAIL clamp_done_cyc got=%0d exp=92", done_cyc); end
    checks++;
    if (seq_err !== 1'b1 || err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL clamp_err got err=%b cnt=%0d exp err=1 cnt=1", seq_err, err_cnt);
    end
    checks++;
    if (tbl_raddr !== 9'd24) begin failures++; $display("FAIL clamp_raddr got=%0d exp=24", tbl_raddr); end
    $display("test_clamp done: strobes=%0d", n_valid);
  endtask

  task automatic test_ignored();
    do_reset();
    load_normal(8'd2);
    run_seq(5, 10, 1'b1, 200);
    checks++;
    if (n_valid !== 2 || valid_cyc[0] !== 22 || valid_cyc[1] !== 46) begin
      failures++;
      $display("FAIL ign_strobes got n=%0d c0=%0d c1=%0d exp n=2 c0=22 c1=46", n_valid, valid_cyc[0], valid_cyc[1]);
    end
    checks++;
    if (valid_data[1] !== 48'h830020000040) begin
      failures++;
      $display("FAIL ign_desc1 got=%h exp=830020000040", valid_data[1]);
    end
    checks++;
    if (done_cyc !== 52 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL ign_done got cyc=%0d err=%b exp cyc=52 err=0", done_cyc, seq_err);
    end
    repeat (3) @(negedge sys_clk_50m);
    checks++;
    if (seq_busy !== 1'b0) begin failures++; $display("FAIL ign_no_queue got busy=%b exp=0", seq_busy); end
    $display("test_ignored done: done_cyc=%0d", done_cyc);
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    bit saw_busy;
    do_reset();
    load_normal(8'd1);
    run_seq(-1, -1, 1'b0, 200);
    load_normal(8'd2);
    @(negedge sys_clk_50m);
    seq_start = 1'b1;
    @(negedge sys_clk_50m);
    seq_start = 1'b0;
    repeat (23) @(negedge sys_clk_50m);
    #2 sys_rst = 1'b1;
    #1;
    checks++;
    if ({seq_busy, seq_done, seq_err, byte6_valid, err_cnt, cmd_idx, tbl_raddr, byte6_data} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got busy=%b done=%b err=%b valid=%b cnt=%0d idx=%0d addr=%0d data=%h exp all zero",
               seq_busy, seq_done, seq_err, byte6_valid, err_cnt, cmd_idx, tbl_raddr, byte6_data);
    end
    repeat (2) @(negedge sys_clk_50m);
    sys_rst = 1'b0;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk_50m);
      if (seq_done === 1'b1) saw_done = 1'b1;
      if (seq_busy === 1'b1) saw_busy = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || saw_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_quiet got done=%b busy=%b exp 0 0", saw_done, saw_busy);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_saturation();
    mem[0] = 8'd1;
    for (int i = 0; i < 256; i++) begin
      run_seq(-1, -1, 1'b0, 100);
      if (i == 254) begin
        checks++;
        if (err_cnt !== 8'd255) begin failures++; $display("FAIL sat_255 got=%0d exp=255", err_cnt); end
      end
    end
    checks++;
    if (err_cnt !== 8'd255 || seq_err !== 1'b1) begin
      failures++;
      $display("FAIL sat_hold got cnt=%0d err=%b exp cnt=255 err=1", err_cnt, seq_err);
    end
    $display("test_saturation done: err_cnt=%0d", err_cnt);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'd0;
    test_reset();
    test_normal();
    test_empty();
    test_timeout();
    test_clamp();
    test_ignored();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Table-driven scheduler for the data-move engine. On a start pulse it reads a command count and a list of 6-byte move descriptors from a byte-wide descriptor table RAM. It issues each descriptor to the data-move engine as a single byte6_valid/byte6_data strobe and waits for move_done before issuing the next one. A timeout aborts the sequence if the engine stalls. The block sits between the cycle-control logic and the data-move engine, so no other master drives byte6_valid.

## Interface
- MAX_CMDS, 64: maximum descriptors per sequence (1..64).
- TIMEOUT, 1000: cycles allowed from issue to move_done (2..65535).
- sys_clk_50m  in  1  system clock; everything on the rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- seq_start  in  1  one-cycle start request; accepted only in IDLE.
- seq_busy  out  1  high from the cycle after an accepted start until the sequence ends.
- seq_done  out  1  one-cycle pulse at sequence end, on both normal and abort.
- seq_err  out  1  sticky error flag; cleared by the next accepted seq_start.
- err_cnt  out  8  saturating count of timeouts and clamps; cleared only by reset.
- cmd_idx  out  6  index of the descriptor currently being fetched or issued.
- tbl_raddr  out  9  descriptor table byte address.
- tbl_rdata  in  8  table read data, valid 2 cycles after tbl_raddr is presented.
- byte6_valid  out  1  one-cycle descriptor strobe to the data-move engine.
- byte6_data  out  48  descriptor; held stable from issue until the next issue.
- move_done  in  1  completion pulse from the data-move engine.

## Operation
- Table layout:
  - Byte 0 holds the count N.
  - Descriptor k (k=0..N-1) occupies bytes 1+6k .. 6+6k.
  - The first byte of each descriptor maps to byte6_data[47:40], the last byte to [7:0].
- Count clamp: if N > MAX_CMDS, use MAX_CMDS, set seq_err and increment err_cnt (once per sequence).
- States:
  - IDLE: wait for seq_start.
  - RD_CNT: read table byte 0.
  - RD_DESC: read 6 descriptor bytes.
  - ISSUE: drive byte6_valid for one cycle.
  - WAIT_DONE: wait for move_done or timeout.
- Transitions:
  - IDLE -> RD_CNT on seq_start.
  - RD_CNT -> IDLE with seq_done if N=0, else -> RD_DESC.
  - RD_DESC -> ISSUE after the 6th byte is captured.
  - ISSUE -> WAIT_DONE.
  - WAIT_DONE -> RD_DESC on move_done, with cmd_idx+1.
  - WAIT_DONE -> IDLE with seq_done on move_done for the last descriptor.
  - WAIT_DONE -> IDLE with seq_done, seq_err set and err_cnt+1 on timeout (abort; remaining descriptors are skipped).
- Table reads are non-pipelined:
  - Address presented at cycle t, data captured at t+2, next address at t+3.
  - Each byte therefore costs 3 cycles.
- tbl_raddr arithmetic is 9-bit, computed as 1 + 6*cmd_idx + byte index. The maximum is 384, so no wrap occurs.
- move_done is ignored outside WAIT_DONE, including in the ISSUE cycle itself.
- seq_start while seq_busy is ignored: no queuing, and seq_err is not cleared.
- err_cnt saturates at 255.

## Timing
- Reset values:
  - seq_busy, seq_done, seq_err, byte6_valid = 0.
  - err_cnt, cmd_idx, tbl_raddr = 0.
  - byte6_data = 0.
  - State = IDLE.
- Reset mid-sequence: every output and all state return to reset values immediately (asynchronously). No seq_done is generated.
- seq_start sampled at cycle s:
  - seq_busy=1 and tbl_raddr=0 at s+1.
  - The count is captured at s+3.
  - The first descriptor address (1) is presented at s+4.
- First byte6_valid occurs at s+4+18 = s+22; its byte6_data is valid in the same cycle.
- The timeout counter starts at 0 in the cycle after byte6_valid and increments each cycle in WAIT_DONE. A timeout fires when the count reaches TIMEOUT without move_done.
- move_done at cycle d for a non-last descriptor: the next descriptor's first address is presented at d+1.
- move_done at cycle d for the last descriptor: seq_done=1 and seq_busy=0 at d+1.
- A timeout at cycle d behaves the same: seq_done=1, seq_busy=0 at d+1, and seq_err=1 from d+1.
- N=0 with count captured at s+3: seq_done=1 and seq_busy=0 at s+4, and byte6_valid never asserts.
- A move_done coinciding with the timeout cycle counts as success.

## Test plan
- Normal sequence:
  - Stimulus: N=2, descriptors 0x5A1234_091000 and 0x830020_000040; move_done 5 cycles after each strobe.
  - Required: byte6_valid at s+22 with 0x5A1234091000, then at s+46 with 0x830020000040; seq_done at s+52; seq_err=0, err_cnt=0.
- Empty table:
  - Stimulus: N=0.
  - Required: seq_done at s+4, no byte6_valid, seq_err=0.
- Timeout:
  - Stimulus: TIMEOUT=20, N=3, move_done never asserted.
  - Required: exactly one byte6_valid, seq_done 21 cycles later, seq_err=1, err_cnt=1, cmd_idx=0.
- Count clamp:
  - Stimulus: MAX_CMDS=4, N=100, move_done after each strobe.
  - Required: exactly 4 byte6_valid strobes, seq_err=1, err_cnt=1, last tbl_raddr=24.
- Ignored inputs:
  - Stimulus: seq_start pulsed while busy, and move_done pulsed in the ISSUE cycle.
  - Required: both are ignored; the sequence completes unchanged.
- Reset and saturation:
  - Stimulus: sys_rst asserted mid-WAIT_DONE, then 256 forced timeouts.
  - Required: after reset, all outputs return to reset values with no seq_done; after the 256 timeouts, err_cnt holds at 255.
